// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Bytes touched by an access; undefined encodings report 4 and are rejected elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      F3_W:        access_size = 3'd4;
      default:     access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational request checker: alignment, funct3/kind legality and
// address range against the data memory size.
module lsu_check
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] last_byte;

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase

    // Highest byte touched, compared as a plain 32-bit value
    last_byte = addr + 32'(access_size(funct3)) - 32'd1;

    illegal = (is_load == is_store)
           || (funct3 inside {3'b011, 3'b110, 3'b111})
           || (is_store && (funct3 == F3_BU || funct3 == F3_HU))
           || (last_byte >= 32'(DEPTH));
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: validates one request at a time, strobes the data
// memory for MEM_LAT cycles and returns a registered writeback response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDRW   = $clog2(DEPTH),
  parameter int unsigned MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_is_load,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic [ADDRW-1:0] mem_addr,
  output logic [2:0]       mem_sel,
  output logic             mem_write_data,
  output logic             mem_read_data,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             stall,
  output logic             resp_valid,
  output logic             resp_is_load,
  output logic [31:0]      resp_rdata,
  output logic [4:0]       resp_rd,
  output logic             misaligned,
  output logic             access_fault,
  output logic [31:0]      fault_addr
);

  localparam int unsigned     CNTW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             lat_load_q, lat_load_d;
  logic [4:0]       lat_rd_q, lat_rd_d;
  logic             chk_misaligned, chk_illegal, accept;

  logic [ADDRW-1:0] mem_addr_d;
  logic [2:0]       mem_sel_d;
  logic [31:0]      mem_wdata_d;
  logic             mem_write_data_d, mem_read_data_d;
  logic             resp_valid_d, resp_is_load_d;
  logic [31:0]      resp_rdata_d;
  logic [4:0]       resp_rd_d;
  logic             misaligned_d, access_fault_d;
  logic [31:0]      fault_addr_d;

  lsu_check #(.DEPTH(DEPTH)) u_check (
    .is_load    (req_is_load),
    .is_store   (req_is_store),
    .funct3     (req_funct3),
    .addr       (req_addr),
    .misaligned (chk_misaligned),
    .illegal    (chk_illegal)
  );

  // Upstream is frozen from the accepting cycle through the last strobe cycle
  assign stall = accept | (state_q == ACCESS);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    lat_load_d       = lat_load_q;
    lat_rd_d         = lat_rd_q;
    mem_addr_d       = mem_addr;
    mem_sel_d        = mem_sel;
    mem_wdata_d      = mem_wdata;
    mem_write_data_d = 1'b0;
    mem_read_data_d  = 1'b0;
    resp_valid_d     = 1'b0;
    resp_is_load_d   = resp_is_load;
    resp_rdata_d     = resp_rdata;
    resp_rd_d        = resp_rd;
    misaligned_d     = 1'b0;
    access_fault_d   = 1'b0;
    fault_addr_d     = fault_addr;
    accept           = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (chk_misaligned) begin
            misaligned_d = 1'b1;
            fault_addr_d = req_addr;
          end else if (chk_illegal) begin
            access_fault_d = 1'b1;
            fault_addr_d   = req_addr;
          end else begin
            accept           = 1'b1;
            state_d          = ACCESS;
            cnt_d            = '0;
            lat_load_d       = req_is_load;
            lat_rd_d         = req_rd;
            mem_addr_d       = req_addr[ADDRW-1:0];
            mem_sel_d        = req_funct3;
            mem_wdata_d      = req_wdata;
            mem_write_data_d = req_is_store;
            mem_read_data_d  = req_is_load;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_is_load_d = lat_load_q;
          resp_rd_d      = lat_rd_q;
          if (lat_load_q) resp_rdata_d = mem_rdata;
        end else begin
          cnt_d            = cnt_q + CNTW'(1);
          mem_write_data_d = ~lat_load_q;
          mem_read_data_d  = lat_load_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lat_load_q     <= 1'b0;
      lat_rd_q       <= '0;
      mem_addr       <= '0;
      mem_sel        <= '0;
      mem_wdata      <= '0;
      mem_write_data <= 1'b0;
      mem_read_data  <= 1'b0;
      resp_valid     <= 1'b0;
      resp_is_load   <= 1'b0;
      resp_rdata     <= '0;
      resp_rd        <= '0;
      misaligned     <= 1'b0;
      access_fault   <= 1'b0;
      fault_addr     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_load_q     <= lat_load_d;
      lat_rd_q       <= lat_rd_d;
      mem_addr       <= mem_addr_d;
      mem_sel        <= mem_sel_d;
      mem_wdata      <= mem_wdata_d;
      mem_write_data <= mem_write_data_d;
      mem_read_data  <= mem_read_data_d;
      resp_valid     <= resp_valid_d;
      resp_is_load   <= resp_is_load_d;
      resp_rdata     <= resp_rdata_d;
      resp_rd        <= resp_rd_d;
      misaligned     <= misaligned_d;
      access_fault   <= access_fault_d;
      fault_addr     <= fault_addr_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT 1 and 3) share one request
// stream, each with its own data memory, checked every cycle against a timeline model.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;

  logic [AW-1:0] mem_addr_o  [2];
  logic [2:0]    mem_sel_o   [2];
  logic          wr_o        [2];
  logic          rds_o       [2];
  logic [31:0]   mem_wdata_o [2];
  logic          stall_o     [2];
  logic          rv_o        [2];
  logic          ril_o       [2];
  logic [31:0]   rdata_o     [2];
  logic [4:0]    rd_o        [2];
  logic          mis_o       [2];
  logic          af_o        [2];
  logic [31:0]   fa_o        [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int wr_cnt [2];
  int rd_cnt [2];
  int rv_cnt [2];

  // Transaction-level model state
  logic [7:0]  ref_mem [DEPTH];
  int          m_rc = -100;
  int          m_out = 0;
  logic        m_load = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_new = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] prev_rdata = '0, prev_fault = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  mem [DEPTH];
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata;

    load_store_unit #(.DEPTH(DEPTH), .MEM_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_is_load    (req_is_load),
      .req_is_store   (req_is_store),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_rd         (req_rd),
      .mem_addr       (mem_addr_o[g]),
      .mem_sel        (mem_sel_o[g]),
      .mem_write_data (wr_o[g]),
      .mem_read_data  (rds_o[g]),
      .mem_wdata      (mem_wdata_o[g]),
      .mem_rdata      (rdata),
      .stall          (stall_o[g]),
      .resp_valid     (rv_o[g]),
      .resp_is_load   (ril_o[g]),
      .resp_rdata     (rdata_o[g]),
      .resp_rd        (rd_o[g]),
      .misaligned     (mis_o[g]),
      .access_fault   (af_o[g]),
      .fault_addr     (fa_o[g])
    );

    initial for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;

    // Byte-addressed data memory: writes on strobe, sign/zero extension by sel on read
    always @(posedge clk) begin
      if (wr_o[g]) begin
        mem[mem_addr_o[g]] = mem_wdata_o[g][7:0];
        if (mem_sel_o[g][1:0] != 2'b00) mem[mem_addr_o[g] + 8'd1] = mem_wdata_o[g][15:8];
        if (mem_sel_o[g][1:0] == 2'b10) begin
          mem[mem_addr_o[g] + 8'd2] = mem_wdata_o[g][23:16];
          mem[mem_addr_o[g] + 8'd3] = mem_wdata_o[g][31:24];
        end
      end
    end

    assign b0 = mem[mem_addr_o[g]];
    assign b1 = mem[mem_addr_o[g] + 8'd1];
    assign b2 = mem[mem_addr_o[g] + 8'd2];
    assign b3 = mem[mem_addr_o[g] + 8'd3];

    always_comb begin
      rdata = '0;
      case (mem_sel_o[g])
        3'b000:  rdata = {{24{b0[7]}}, b0};
        3'b001:  rdata = {{16{b1[7]}}, b1, b0};
        3'b010:  rdata = {b3, b2, b1, b0};
        3'b100:  rdata = {24'd0, b0};
        3'b101:  rdata = {16'd0, b1, b0};
        default: rdata = '0;
      endcase
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // 0 = accepted, 1 = misaligned, 2 = access fault
  function automatic int classify(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a);
    logic [31:0] last;
    if ((f3[1:0] == 2'b01 || f3[1:0] == 2'b10) && (a % size_of(f3) != 0)) return 1;
    if (ld == st) return 2;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 2;
    if (st && f3[2]) return 2;
    last = a + 32'(size_of(f3)) - 32'd1;
    if (last >= 32'(DEPTH)) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned n = size_of(f3);
    logic [31:0] v = '0;
    for (int k = 0; k < int'(n); k++) v = v | (32'(ref_mem[8'(a + 32'(k))]) << (8 * k));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w);
    for (int k = 0; k < int'(size_of(f3)); k++) ref_mem[8'(a + 32'(k))] = w[8 * k +: 8];
  endtask

  // Expected outputs of instance i in the current cycle, derived from request timing
  task automatic check_cycle(input int i);
    int l;
    bit ok, act, rv;
    logic [31:0] e_rdata, e_fa;
    l   = (i == 0) ? 1 : 3;
    ok  = (m_rc >= 0) && (m_out == 0);
    act = ok && cyc >= m_rc + 1 && cyc <= m_rc + l;
    rv  = ok && cyc == m_rc + l + 1;
    chk("stall", i, 32'(stall_o[i]), 32'(ok && cyc >= m_rc && cyc <= m_rc + l));
    chk("write_strobe", i, 32'(wr_o[i]), 32'(act && !m_load));
    chk("read_strobe", i, 32'(rds_o[i]), 32'(act && m_load));
    if (act) begin
      chk("mem_addr", i, 32'(mem_addr_o[i]), 32'(m_addr[7:0]));
      chk("mem_sel", i, 32'(mem_sel_o[i]), 32'(m_f3));
      chk("mem_wdata", i, mem_wdata_o[i], m_wdata);
    end
    chk("resp_valid", i, 32'(rv_o[i]), 32'(rv));
    if (rv) begin
      chk("resp_is_load", i, 32'(ril_o[i]), 32'(m_load));
      if (m_load) chk("resp_rd", i, 32'(rd_o[i]), 32'(m_rd));
    end
    e_rdata = (ok && m_load && cyc >= m_rc + l + 1) ? m_new : prev_rdata;
    chk("resp_rdata", i, rdata_o[i], e_rdata);
    chk("misaligned", i, 32'(mis_o[i]), 32'(m_rc >= 0 && m_out == 1 && cyc == m_rc + 1));
    chk("access_fault", i, 32'(af_o[i]), 32'(m_rc >= 0 && m_out == 2 && cyc == m_rc + 1));
    e_fa = (m_rc >= 0 && m_out != 0 && cyc >= m_rc + 1) ? m_addr : prev_fault;
    chk("fault_addr", i, fa_o[i], e_fa);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check_cycle(i);
        if (wr_o[i]) wr_cnt[i]++;
        if (rds_o[i]) rd_cnt[i]++;
        if (rv_o[i]) rv_cnt[i]++;
      end
    end
  end

  // One request, five cycles long; optional junk on req_* while busy, optional reset at cycle rst_at
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd, input bit junk, input int rst_at);
    @(posedge clk); #1;
    if (m_rc >= 0) begin
      if (m_out == 0 && m_load) prev_rdata = m_new;
      if (m_out != 0) prev_fault = m_addr;
    end
    m_out = classify(ld, st, f3, a);
    m_rc = cyc; m_load = ld; m_addr = a; m_f3 = f3; m_wdata = w; m_rd = rd;
    if (m_out == 0 && ld) m_new = ref_load(a, f3);
    if (m_out == 0 && st) ref_store(a, f3, w);
    for (int i = 0; i < 2; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; rv_cnt[i] = 0; end
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = w; req_rd = rd;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (junk && m_out == 0 && k <= 2 && rst_at == 0) begin
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_funct3 = 3'b010; req_addr = 32'($urandom_range(0, 63)) * 4; req_rd = 5'($urandom);
      end
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) begin
        rst = 1'b0; m_rc = -100; prev_rdata = '0; prev_fault = '0;
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
    for (int i = 0; i < 2; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; rv_cnt[i] = 0; end
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_addr", i, 32'(mem_addr_o[i]), 32'd0);
      chk("rst_mem_sel", i, 32'(mem_sel_o[i]), 32'd0);
      chk("rst_mem_wdata", i, mem_wdata_o[i], 32'd0);
      chk("rst_resp_rd", i, 32'(rd_o[i]), 32'd0);
      chk("rst_resp_is_load", i, 32'(ril_o[i]), 32'd0);
    end

    // Word store then load back
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 0);
    chk("sw_strobe_len", 0, 32'(wr_cnt[0]), 32'd1);
    chk("sw_strobe_len", 1, 32'(wr_cnt[1]), 32'd3);
    chk("sw_resp_count", 0, 32'(rv_cnt[0]), 32'd1);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd3, 1'b0, 0);
    chk("lit_model_lw", 0, m_new, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) chk("lit_lw", i, rdata_o[i], 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads
    issue(1'b0, 1'b1, 3'b000, 32'h20, 32'h00000080, 5'd0, 1'b0, 0);
    issue(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 5'd9, 1'b1, 0);
    for (int i = 0; i < 2; i++) chk("lit_lb", i, rdata_o[i], 32'hFFFFFF80);
    issue(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 5'd7, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("lit_lbu", i, rdata_o[i], 32'h00000080);
      chk("lit_lbu_rd", i, 32'(rd_o[i]), 32'd7);
    end

    // Alignment faults
    issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 5'd1, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("lit_mis_addr", i, fa_o[i], 32'h12);
      chk("lit_mis_no_resp", i, 32'(rv_cnt[i]), 32'd0);
      chk("lit_mis_no_strobe", i, 32'(rd_cnt[i]), 32'd0);
    end
    issue(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 5'd1, 1'b0, 0);
    for (int i = 0; i < 2; i++) chk("lit_mis_h", i, fa_o[i], 32'h13);

    // Range edge and illegal store width
    issue(1'b0, 1'b1, 3'b010, 32'hFC, 32'h12345678, 5'd0, 1'b0, 0);
    issue(1'b1, 1'b0, 3'b010, 32'hFC, 32'h0, 5'd4, 1'b0, 0);
    for (int i = 0; i < 2; i++) chk("lit_lw_top", i, rdata_o[i], 32'h12345678);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 1'b0, 0);
    for (int i = 0; i < 2; i++) chk("lit_af_range", i, fa_o[i], 32'h100);
    issue(1'b0, 1'b1, 3'b101, 32'h30, 32'h5555, 5'd0, 1'b0, 0);
    for (int i = 0; i < 2; i++) chk("lit_af_sh101", i, fa_o[i], 32'h30);

    // Halfword load length, then reset during the second access cycle
    issue(1'b1, 1'b0, 3'b001, 32'h40, 32'h0, 5'd2, 1'b0, 0);
    chk("lh_strobe_len", 0, 32'(rd_cnt[0]), 32'd1);
    chk("lh_strobe_len", 1, 32'(rd_cnt[1]), 32'd3);
    issue(1'b1, 1'b0, 3'b001, 32'h40, 32'h0, 5'd2, 1'b0, 2);
    chk("rst_abort_resp", 1, 32'(rv_cnt[1]), 32'd0);
    for (int i = 0; i < 2; i++) chk("rst_abort_rdata", i, rdata_o[i], 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b0, 0);
    for (int i = 0; i < 2; i++) chk("post_rst_lw", i, rdata_o[i], 32'hDEADBEEF);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        ld = 1'($urandom_range(0, 1)); st = ~ld;
      end else begin
        ld = 1'($urandom); st = 1'($urandom);
      end
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 255));
        2:       a = 32'($urandom_range(240, 272));
        default: a = $urandom();
      endcase
      if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b00) a = a & ~32'(size_of(f3) - 1);
      issue(ld, st, f3, a, $urandom(), 5'($urandom), 1'($urandom), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
